uart_relay_axi_master: RTL and testbench

UART_RELAY_AXI_MASTER -- requirements
Module: uart_relay_axi_master

---
 rtl/uart_relay_axi_master.sv | 186 ++++++++++++++++++
 tb/tb_uart_relay_axi_master.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_relay_axi_master.sv
// UART-to-UART relay: polls a source UART over AXI-Lite reads,
// buffers a frame, then writes it byte by byte to a destination UART.
module uart_relay_axi_master #(
  parameter int BUF_DEPTH   = 64,
  parameter bit FLUSH_ON_LF = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       s_araddr,
  output logic             s_arvalid,
  input  logic             s_arready,
  input  logic [31:0]      s_rdata,
  input  logic [1:0]       s_rresp,
  input  logic             s_rvalid,
  output logic             s_rready,
  output logic [3:0]       d_araddr,
  output logic             d_arvalid,
  input  logic             d_arready,
  input  logic [31:0]      d_rdata,
  input  logic             d_rvalid,
  output logic             d_rready,
  output logic [3:0]       d_awaddr,
  output logic             d_awvalid,
  input  logic             d_awready,
  output logic [31:0]      d_wdata,
  output logic [3:0]       d_wstrb,
  output logic             d_wvalid,
  input  logic             d_wready,
  input  logic [1:0]       d_bresp,
  input  logic             d_bvalid,
  output logic             d_bready,
  output logic             busy_tx,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(BUF_DEPTH);

  localparam logic [2:0] RX_STAT   = 3'd0;
  localparam logic [2:0] RX_STAT_W = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_DATA_W = 3'd3;
  localparam logic [2:0] TX_STAT   = 3'd4;
  localparam logic [2:0] TX_STAT_W = 3'd5;
  localparam logic [2:0] TX_WR     = 3'd6;
  localparam logic [2:0] TX_B      = 3'd7;

  logic [2:0]  state;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [BUF_DEPTH];

  logic [AW:0] wr_nxt;
  logic [AW:0] rd_nxt;
  logic [7:0]  rx_byte;
  logic        s_rbeat;
  logic        d_rbeat;
  logic        d_bbeat;
  logic        s_rok;
  logic        store;
  logic        err_ev;
  logic        aw_done;
  logic        w_done;
  logic        flush;

  assign wr_nxt  = wr_ptr + 1'b1;
  assign rd_nxt  = rd_ptr + 1'b1;
  assign rx_byte = s_rdata[7:0];
  assign s_rok   = (s_rresp == 2'b00);

  // R is only accepted once the AR of the same wait state has gone out
  assign s_rready = !s_arvalid &&
                    (state == RX_STAT_W || state == RX_DATA_W);
  assign d_rready = !d_arvalid && (state == TX_STAT_W);
  assign d_bready = (state == TX_B);
  assign busy_tx  = state[2];

  assign s_rbeat = s_rvalid && s_rready;
  assign d_rbeat = d_rvalid && d_rready;
  assign d_bbeat = d_bvalid && d_bready;
  assign store   = (state == RX_DATA_W) && s_rbeat && s_rok;
  assign err_ev  = (s_rbeat && !s_rok) ||
                   (d_bbeat && d_bresp != 2'b00);
  assign aw_done = !d_awvalid || d_awready;
  assign w_done  = !d_wvalid || d_wready;
  assign flush   = (wr_nxt == FULL) ||
                   (FLUSH_ON_LF && rx_byte == 8'h0A);

  // Frame buffer storage; reset discards contents via the pointers
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  // Relay FSM with its AXI request registers and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_STAT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_cnt    <= '0;
      frame_done <= 1'b0;
      s_araddr   <= 4'h0;
      s_arvalid  <= 1'b0;
      d_araddr   <= 4'h0;
      d_arvalid  <= 1'b0;
      d_awaddr   <= 4'h0;
      d_awvalid  <= 1'b0;
      d_wdata    <= 32'h0;
      d_wstrb    <= 4'h0;
      d_wvalid   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (err_ev && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
      if (s_arready) s_arvalid <= 1'b0;
      if (d_arready) d_arvalid <= 1'b0;
      case (state)
        RX_STAT: begin
          s_araddr  <= 4'h8;
          s_arvalid <= 1'b1;
          state     <= RX_STAT_W;
        end
        RX_STAT_W: begin
          if (s_rbeat)
            state <= (s_rok && s_rdata[0]) ? RX_DATA : RX_STAT;
        end
        RX_DATA: begin
          s_araddr  <= 4'h0;
          s_arvalid <= 1'b1;
          state     <= RX_DATA_W;
        end
        RX_DATA_W: begin
          if (s_rbeat) begin
            if (!s_rok) begin
              state <= RX_STAT;
            end else begin
              wr_ptr <= wr_nxt;
              state  <= flush ? TX_STAT : RX_STAT;
            end
          end
        end
        TX_STAT: begin
          d_araddr  <= 4'h8;
          d_arvalid <= 1'b1;
          state     <= TX_STAT_W;
        end
        TX_STAT_W: begin
          if (d_rbeat) begin
            if (d_rdata[3]) begin
              state <= TX_STAT;
            end else begin
              d_awaddr  <= 4'h4;
              d_awvalid <= 1'b1;
              d_wdata   <= {24'h0, mem[rd_ptr[AW-1:0]]};
              d_wstrb   <= 4'b0001;
              d_wvalid  <= 1'b1;
              state     <= TX_WR;
            end
          end
        end
        TX_WR: begin
          if (d_awready) d_awvalid <= 1'b0;
          if (d_wready)  d_wvalid  <= 1'b0;
          if (aw_done && w_done) state <= TX_B;
        end
        TX_B: begin
          if (d_bvalid) begin
            if (rd_nxt == wr_ptr) begin
              rd_ptr     <= '0;
              wr_ptr     <= '0;
              frame_done <= 1'b1;
              state      <= RX_STAT;
            end else begin
              rd_ptr <= rd_nxt;
              state  <= TX_STAT;
            end
          end
        end
        default: state <= RX_STAT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_relay_axi_master.sv
// Bench for uart_relay_axi_master: behavioural AXI-Lite UART slaves
// plus a byte-stream frame model.
module tb_uart_relay_axi_master;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [3:0]  d_araddr;
  logic        d_arvalid;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rready;
  logic [3:0]  d_awaddr;
  logic        d_awvalid;
  logic        d_awready;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wvalid;
  logic        d_wready;
  logic [1:0]  d_bresp;
  logic        d_bvalid;
  logic        d_bready;
  logic        busy_tx;
  logic        frame_done;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_relay_axi_master #(
    .BUF_DEPTH(DEPTH), .FLUSH_ON_LF(1), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_wvalid(d_wvalid),
    .d_wready(d_wready), .d_bresp(d_bresp),
    .d_bvalid(d_bvalid), .d_bready(d_bready),
    .busy_tx(busy_tx), .frame_done(frame_done),
    .err_cnt(err_cnt)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit rnd_dly = 0;
  int awdly_cfg = -1;
  int wdly_cfg = -1;

  function automatic int pick(input int cfg);
    if (cfg >= 0) return cfg;
    return rnd_dly ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Source UART slave state
  byte unsigned src_q[$];
  bit          s_err_next = 0;
  bit          s_arm = 1;
  logic [3:0]  s_first = 4'hF;
  int          s_stat_reads = 0;
  int          s_data_reads = 0;
  logic [3:0]  s_cur;
  bit          s_have, s_ap, s_rp;
  int          s_adly, s_rdly;

  initial begin
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_have = 0; s_ap = 0; s_rp = 0; s_adly = 0; s_rdly = 0;
    s_cur = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_arready = 0; s_rvalid = 0;
        s_have = 0; s_ap = 0; s_rp = 0;
        continue;
      end
      if (s_ap) begin
        s_arready = 0; s_have = 1; s_ap = 0;
        s_rdly = pick(-1);
      end
      if (s_rp) begin
        s_rvalid = 0; s_have = 0; s_rp = 0;
        if (s_cur == 4'h8) begin
          s_stat_reads++;
        end else begin
          s_data_reads++;
          if (src_q.size() > 0) void'(src_q.pop_front());
          if (s_rresp != 0) s_err_next = 0;
        end
      end
      if (s_arvalid && !s_arready && !s_have) begin
        if (s_adly <= 1) s_arready = 1;
        else s_adly--;
      end
      if (!s_arvalid) s_adly = pick(-1);
      if (s_have && !s_rvalid) begin
        if (s_rdly <= 0) begin
          s_rvalid = 1;
          if (s_cur == 4'h8) begin
            s_rdata = {31'h0, src_q.size() > 0};
            s_rresp = 2'b00;
          end else begin
            s_rdata = {24'hA5A5A5,
                       src_q.size() > 0 ? src_q[0] : 8'h00};
            s_rresp = s_err_next ? 2'b10 : 2'b00;
          end
        end else begin
          s_rdly--;
        end
      end
      s_ap = s_arvalid && s_arready;
      if (s_ap) begin
        s_cur = s_araddr;
        if (s_arm) begin
          s_first = s_araddr;
          s_arm = 0;
        end
      end
      s_rp = s_rvalid && s_rready;
    end
  end

  // Destination UART slave state
  int          d_full = 0;
  int          d_stat_reads = 0;
  int          d_bad_ar = 0;
  bit          d_have, d_ap, d_rp;
  int          d_adly, d_rdly;
  logic [3:0]  d_cur;
  logic [31:0] got_w[$];
  int          n_b = 0;
  int          berr_idx = -1;
  int          bad_fmt = 0;
  bit          aw_got, w_got, aw_p, w_p, b_p;
  int          awdly, wdly, bdly;
  int          aw_hi, w_hi, last_aw_hi, last_w_hi;
  logic [3:0]  aw_cap;
  logic [3:0]  ws_cap;
  logic [31:0] w_cap;

  initial begin
    d_arready = 0; d_rvalid = 0; d_rdata = 0;
    d_awready = 0; d_wready = 0; d_bvalid = 0; d_bresp = 0;
    d_have = 0; d_ap = 0; d_rp = 0; d_adly = 0; d_rdly = 0;
    aw_got = 0; w_got = 0; aw_p = 0; w_p = 0; b_p = 0;
    awdly = 0; wdly = 0; bdly = 0; aw_hi = 0; w_hi = 0;
    last_aw_hi = 0; last_w_hi = 0; d_cur = 0;
    aw_cap = 0; ws_cap = 0; w_cap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        d_arready = 0; d_rvalid = 0; d_awready = 0;
        d_wready = 0; d_bvalid = 0;
        d_have = 0; d_ap = 0; d_rp = 0;
        aw_got = 0; w_got = 0; aw_p = 0; w_p = 0; b_p = 0;
        aw_hi = 0; w_hi = 0;
        continue;
      end
      if (d_ap) begin
        d_arready = 0; d_have = 1; d_ap = 0;
        d_rdly = pick(-1);
      end
      if (d_rp) begin
        d_rvalid = 0; d_have = 0; d_rp = 0;
        if (d_cur == 4'h8) d_stat_reads++;
        else d_bad_ar++;
        if (d_full > 0) d_full--;
      end
      if (d_arvalid && !d_arready && !d_have) begin
        if (d_adly <= 1) d_arready = 1;
        else d_adly--;
      end
      if (!d_arvalid) d_adly = pick(-1);
      if (d_have && !d_rvalid) begin
        if (d_rdly <= 0) begin
          d_rvalid = 1;
          d_rdata = {28'h0, d_full > 0, 3'b001};
        end else begin
          d_rdly--;
        end
      end
      d_ap = d_arvalid && d_arready;
      if (d_ap) d_cur = d_araddr;
      d_rp = d_rvalid && d_rready;

      if (aw_p) begin
        d_awready = 0; aw_got = 1; aw_p = 0;
        last_aw_hi = aw_hi; aw_hi = 0;
        bdly = pick(-1);
      end
      if (w_p) begin
        d_wready = 0; w_got = 1; w_p = 0;
        last_w_hi = w_hi; w_hi = 0;
      end
      if (b_p) begin
        d_bvalid = 0; b_p = 0;
        got_w.push_back(w_cap);
        if (aw_cap != 4'h4 || ws_cap != 4'h1) bad_fmt++;
        n_b++;
      end
      if (d_awvalid) aw_hi++;
      if (d_wvalid) w_hi++;
      if (d_awvalid && !d_awready && !aw_got) begin
        if (awdly <= 1) d_awready = 1;
        else awdly--;
      end
      if (!d_awvalid) awdly = pick(awdly_cfg);
      if (d_wvalid && !d_wready && !w_got) begin
        if (wdly <= 1) d_wready = 1;
        else wdly--;
      end
      if (!d_wvalid) wdly = pick(wdly_cfg);
      if (aw_got && w_got && !d_bvalid) begin
        if (bdly <= 0) begin
          d_bvalid = 1;
          d_bresp = (n_b == berr_idx) ? 2'b10 : 2'b00;
          aw_got = 0; w_got = 0;
        end else begin
          bdly--;
        end
      end
      aw_p = d_awvalid && d_awready;
      if (aw_p) aw_cap = d_awaddr;
      w_p = d_wvalid && d_wready;
      if (w_p) begin
        w_cap = d_wdata;
        ws_cap = d_wstrb;
      end
      b_p = d_bvalid && d_bready;
    end
  end

  // frame_done pulse monitor
  int fd_cnt = 0;
  int fd_long = 0;
  bit fd_prev = 0;
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (frame_done && fd_prev) fd_long++;
    fd_prev = frame_done;
  end

  // Reference model: accepted bytes in order, frames end
  // on LF or when DEPTH bytes have gathered
  byte unsigned exp_w[$];
  int m_cnt = 0;
  int m_frames = 0;
  int m_err = 0;

  task automatic send(input byte unsigned b, input bit bad);
    src_q.push_back(b);
    if (bad) begin
      m_err++;
      return;
    end
    exp_w.push_back(b);
    m_cnt++;
    if (b == 8'h0A || m_cnt == DEPTH) begin
      m_frames++;
      m_cnt = 0;
    end
  endtask

  task automatic wait_fd(input string tag);
    int c = 0;
    while (fd_cnt < m_frames && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_frames"}, fd_cnt, m_frames);
    repeat (30) @(negedge clk);
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, got_w.size(), exp_w.size());
    n = got_w.size() < exp_w.size() ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), got_w[i], {24'h0, exp_w[i]});
    got_w.delete();
    exp_w.delete();
  endtask

  initial begin
    int c;
    int base;
    int nb;
    byte unsigned b;
    repeat (3) @(negedge clk);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_d_arvalid", d_arvalid, 0);
    chk("rst_d_awvalid", d_awvalid, 0);
    chk("rst_d_wvalid", d_wvalid, 0);
    chk("rst_d_bready", d_bready, 0);
    chk("rst_busy", busy_tx, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", err_cnt, 0);
    rst = 0;

    c = 0;
    while (s_stat_reads < 3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("poll_stat_reads", s_stat_reads, 3);
    chk("poll_first_ar", s_first, 4'h8);
    chk("poll_data_reads", s_data_reads, 0);
    chk("poll_d_reads", d_stat_reads, 0);
    chk("poll_d_writes", n_b, 0);
    chk("poll_busy", busy_tx, 0);

    send(8'h41, 0); send(8'h42, 0); send(8'h0A, 0);
    wait_fd("ab_lf");
    cmp_writes("ab_lf");
    chk("ab_lf_busy", busy_tx, 0);

    rnd_dly = 1;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0A) b = 8'h0B;
          send(b, 0);
        end
      end else begin
        nb = $urandom_range(0, DEPTH - 2);
        for (int i = 0; i < nb; i++) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0A) b = 8'h0B;
          send(b, 0);
        end
        send(8'h0A, 0);
      end
    end
    wait_fd("rnd");
    cmp_writes("rnd");
    rnd_dly = 0;

    base = d_stat_reads;
    d_full = 5;
    send(8'h5A, 0); send(8'h0A, 0);
    wait_fd("txfull");
    chk("txfull_polls", d_stat_reads - base, 7);
    cmp_writes("txfull");

    awdly_cfg = 3;
    wdly_cfg = 0;
    base = n_b;
    send(8'h0A, 0);
    wait_fd("awdly");
    chk("awdly_aw_hi", last_aw_hi, 3);
    chk("awdly_w_hi", last_w_hi, 1);
    chk("awdly_nb", n_b - base, 1);
    cmp_writes("awdly");
    awdly_cfg = -1;
    wdly_cfg = -1;

    s_err_next = 1;
    send(8'h78, 1); send(8'h79, 0); send(8'h0A, 0);
    wait_fd("rerr");
    cmp_writes("rerr");
    chk("rerr_err", err_cnt, m_err);

    base = n_b;
    berr_idx = base + 1;
    awdly_cfg = 12;
    src_q.push_back(8'h61); src_q.push_back(8'h62);
    src_q.push_back(8'h63); src_q.push_back(8'h0A);
    c = 0;
    while (n_b < base + 2 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("berr_nb", n_b - base, 2);
    chk("berr_err", err_cnt, m_err + 1);
    c = 0;
    while (!d_awvalid && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("berr_aw3", d_awvalid, 1);
    @(negedge clk);
    rst = 1;
    s_arm = 1;
    @(negedge clk);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_awvalid", d_awvalid, 0);
    chk("mid_rst_wvalid", d_wvalid, 0);
    chk("mid_rst_s_arvalid", s_arvalid, 0);
    chk("mid_rst_busy", busy_tx, 0);
    chk("mid_rst_bready", d_bready, 0);
    m_err = 0;
    awdly_cfg = -1;
    berr_idx = -1;
    src_q.delete();
    rst = 0;
    c = 0;
    while (s_arm && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("post_rst_ar", s_first, 4'h8);
    repeat (60) @(negedge clk);
    chk("post_rst_nb", n_b - base, 2);
    chk("post_rst_w0", got_w.size() > 0 ? got_w[0] : 0, 32'h61);
    chk("post_rst_w1", got_w.size() > 1 ? got_w[1] : 0, 32'h62);
    chk("post_rst_busy", busy_tx, 0);
    chk("fmt_bad", bad_fmt, 0);
    chk("d_bad_ar", d_bad_ar, 0);
    chk("fd_width", fd_long, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
